// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between fetch and data.
// Data has fixed priority; a starvation counter guarantees fetch progress.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ifetch_req,
    input  logic [ADDR_WIDTH-1:0] ifetch_addr,
    output logic                  ifetch_ready,
    output logic                  ifetch_rvalid,
    output logic [DATA_WIDTH-1:0] ifetch_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    input  logic [3:0]            data_wmask,
    output logic                  data_ready,
    output logic                  data_rvalid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       data_win;
    logic       fetch_win;

    // Winner pick: data first unless fetch has waited LIMIT data grants.
    always_comb begin
        data_win  = data_req && ((starve_q < LIMIT) || !ifetch_req);
        fetch_win = ifetch_req && !data_win;
    end

    // Starvation counter: counts data grants that overtook a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (!ifetch_req) begin
            starve_d = '0;
        end else if (state_q == IDLE && fetch_win) begin
            starve_d = '0;
        end else if (state_q == IDLE && data_win && starve_q < LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Grant/response sequencing and all master/memory outputs.
    // Outputs are forced quiet while resetn is low, even with requests up.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        ifetch_ready  = 1'b0;
        ifetch_rvalid = 1'b0;
        ifetch_rdata  = '0;
        data_ready    = 1'b0;
        data_rvalid   = 1'b0;
        data_rdata    = '0;
        mem_en        = 1'b0;
        mem_we        = 4'b0000;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (resetn) begin
            unique case (state_q)
                IDLE: begin
                    if (data_win) begin
                        data_ready = 1'b1;
                        mem_en     = 1'b1;
                        mem_addr   = data_addr;
                        mem_wdata  = data_wdata;
                        if (data_we) begin
                            mem_we = data_wmask;
                        end else begin
                            state_d = RESP;
                            owner_d = OWN_DATA;
                        end
                    end else if (fetch_win) begin
                        ifetch_ready = 1'b1;
                        mem_en       = 1'b1;
                        mem_addr     = ifetch_addr;
                        mem_wdata    = data_wdata;
                        state_d      = RESP;
                        owner_d      = OWN_FETCH;
                    end
                end
                RESP: begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                    if (owner_q == OWN_FETCH) begin
                        ifetch_rvalid = 1'b1;
                        ifetch_rdata  = mem_rdata;
                    end
                    if (owner_q == OWN_DATA) begin
                        data_rvalid = 1'b1;
                        data_rdata  = mem_rdata;
                    end
                end
            endcase
        end
    end

    // State, owner and starvation registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

endmodule
